// File: rtl/key_expander_if.sv
// Round-key stream from the AES-128 key expander to the round stage: valid/ready handshake.
interface key_expander_if;
  logic [3:0][3:0][7:0] rk_out;
  logic [3:0]           rk_round;
  logic                 rk_valid;
  logic                 rk_ready;

  modport master (output rk_out, rk_round, rk_valid, input rk_ready);
  modport slave  (input rk_out, rk_round, rk_valid, output rk_ready);
endinterface

// File: rtl/key_expander.sv
// AES-128 key schedule: one round key per clock, streamed 0..10 with the first key valid the cycle after start.
// KEY_EXPANDER_REVERSE_EN adds an 11-entry key buffer and EXPAND state so keys can be emitted 10 down to 0.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  assign y = SBOX[a];
endmodule

module key_expander #(
  parameter int NR = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [3:0][3:0][7:0] key_in,
  input  logic                 reverse,
  output logic                 busy,
  key_expander_if.master       rk
);
  localparam logic [3:0] LAST = 4'(NR);
  typedef logic [3:0][3:0][7:0] key_t;

`ifdef KEY_EXPANDER_REVERSE_EN
  typedef enum logic [1:0] {IDLE, EXPAND, EMIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, EMIT} state_t;
`endif

  state_t          state_q, state_d;
  key_t            cur_q, nxt_key;
  logic [7:0]      rcon_q, rcon_nxt;
  logic [3:0]      round_q;
  logic            fire, last_hs, rev_mode;
  logic [3:0][7:0] sub;

  // RotWord folded into the S-box wiring: row r looks up byte r+1 of the last column.
  for (genvar r = 0; r < 4; r++) begin : g_sbox
    aes_sbox u_sbox (.a(cur_q[(r + 1) % 4][3]), .y(sub[r]));
  end

  always_comb begin
    nxt_key = cur_q;
    for (int r = 0; r < 4; r++) begin
      nxt_key[r][0] = cur_q[r][0] ^ sub[r] ^ ((r == 0) ? rcon_q : 8'h00);
      for (int c = 1; c < 4; c++) nxt_key[r][c] = cur_q[r][c] ^ nxt_key[r][c-1];
    end
  end

  assign rcon_nxt    = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
  assign rk.rk_round = round_q;

`ifdef KEY_EXPANDER_REVERSE_EN
  key_t kbuf [0:10];
  logic rev_q;
  assign rev_mode  = rev_q;
  assign rk.rk_out = rev_q ? kbuf[round_q] : cur_q;
`else
  logic unused_reverse;
  assign unused_reverse = reverse;
  assign rev_mode       = 1'b0;
  assign rk.rk_out      = cur_q;
`endif
  assign last_hs = rev_mode ? (round_q == 4'd0) : (round_q == LAST);

  always_comb begin
    state_d     = state_q;
    busy        = (state_q != IDLE);
    rk.rk_valid = (state_q == EMIT);
    fire        = rk.rk_valid && rk.rk_ready;
    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef KEY_EXPANDER_REVERSE_EN
          state_d = reverse ? EXPAND : EMIT;
`else
          state_d = EMIT;
`endif
        end
      end
`ifdef KEY_EXPANDER_REVERSE_EN
      EXPAND: if (round_q == LAST) state_d = EMIT;
`endif
      EMIT: if (fire && last_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cur_q   <= '0;
      rcon_q  <= 8'h01;
      round_q <= '0;
`ifdef KEY_EXPANDER_REVERSE_EN
      rev_q   <= 1'b0;
      for (int i = 0; i <= 10; i++) kbuf[i] <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            cur_q   <= key_in;
            rcon_q  <= 8'h01;
            round_q <= 4'd0;
`ifdef KEY_EXPANDER_REVERSE_EN
            rev_q   <= reverse;
            kbuf[0] <= key_in;
            if (reverse) round_q <= 4'd1;
`endif
          end
        end
`ifdef KEY_EXPANDER_REVERSE_EN
        // round_q indexes the key being computed; it parks at LAST for the EMIT hand-over.
        EXPAND: begin
          kbuf[round_q] <= nxt_key;
          cur_q         <= nxt_key;
          rcon_q        <= rcon_nxt;
          if (round_q != LAST) round_q <= round_q + 4'd1;
        end
`endif
        EMIT: begin
          if (fire && !last_hs) begin
            if (rev_mode) begin
              round_q <= round_q - 4'd1;
            end else begin
              cur_q   <= nxt_key;
              rcon_q  <= rcon_nxt;
              round_q <= round_q + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_key_expander.sv
// Directed bench for key_expander using the FIPS-197 AES-128 key schedule vectors.
module tb_key_expander;
  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 start = 1'b0;
  logic                 reverse = 1'b0;
  logic                 busy;
  logic [3:0][3:0][7:0] key_in = '0;

  key_expander_if rk ();

  key_expander #(.NR(10)) dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in),
    .reverse(reverse), .busy(busy), .rk(rk)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rdy;
    bit pulse;
    int exp_round;
  } vec_t;

  localparam logic [127:0] KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] OTHER = 128'h000102030405060708090a0b0c0d0e0f;

  logic [127:0] rk_exp [0:10];
  vec_t fwd[$], bp[$], rv[$];
  int nvec = 0;
  int nerr = 0;

  function automatic logic [3:0][3:0][7:0] unflat(input logic [127:0] f);
    logic [3:0][3:0][7:0] k;
    for (int n = 0; n < 16; n++) k[n % 4][n / 4] = f[127 - 8 * n -: 8];
    return k;
  endfunction

  function automatic logic [127:0] flat(input logic [3:0][3:0][7:0] k);
    logic [127:0] f;
    for (int n = 0; n < 16; n++) f[127 - 8 * n -: 8] = k[n % 4][n / 4];
    return f;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [127:0] k, input bit rev);
    start   = 1'b1;
    key_in  = unflat(k);
    reverse = rev;
    @(negedge clk);
    start   = 1'b0;
    reverse = 1'b0;
  endtask

  task automatic run_table(input string tag, input vec_t tbl[$]);
    for (int i = 0; i < tbl.size(); i++) begin
      check({tag, " valid"}, 128'(rk.rk_valid), 128'd1);
      check({tag, " round"}, 128'(rk.rk_round), 128'(tbl[i].exp_round));
      check({tag, " key"}, flat(rk.rk_out), rk_exp[tbl[i].exp_round]);
      rk.rk_ready = tbl[i].rdy;
      start = tbl[i].pulse;
      if (tbl[i].pulse) key_in = unflat(OTHER);
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, " done valid"}, 128'(rk.rk_valid), 128'd0);
    check({tag, " done busy"}, 128'(busy), 128'd0);
  endtask

  initial begin
    int r, k;
    rk_exp[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rk_exp[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rk_exp[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    rk_exp[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk_exp[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk_exp[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk_exp[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk_exp[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk_exp[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    rk_exp[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rk_exp[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    for (int i = 0; i <= 10; i++) fwd.push_back('{rdy: 1'b1, pulse: 1'b0, exp_round: i});
    for (int i = 10; i >= 0; i--) rv.push_back('{rdy: 1'b1, pulse: 1'b0, exp_round: i});
    // ready pattern 1,0,0,1,0,0,...; a foreign start lands mid-stream while busy
    r = 0;
    k = 0;
    while (r <= 10) begin
      bp.push_back('{rdy: (k % 3 == 0), pulse: (k == 4), exp_round: r});
      if (k % 3 == 0) r++;
      k++;
    end

    rk.rk_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset valid", 128'(rk.rk_valid), 128'd0);
    check("reset busy", 128'(busy), 128'd0);
    check("reset round", 128'(rk.rk_round), 128'd0);
    check("reset key", flat(rk.rk_out), 128'd0);
    rst = 1'b1;
    @(negedge clk);
    check("idle busy", 128'(busy), 128'd0);

    start_op(KEY, 1'b0);
    run_table("fwd", fwd);

    start_op(KEY, 1'b0);
    run_table("bp", bp);

`ifdef KEY_EXPANDER_REVERSE_EN
    start_op(KEY, 1'b1);
    for (int i = 0; i < 10; i++) begin
      check("rev expand valid", 128'(rk.rk_valid), 128'd0);
      check("rev expand busy", 128'(busy), 128'd1);
      @(negedge clk);
    end
    run_table("rev", rv);
`else
    start_op(KEY, 1'b1);
    run_table("rev ignored", fwd);
`endif

    start_op(KEY, 1'b0);
    rk.rk_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("mid round", 128'(rk.rk_round), 128'd5);
    check("mid key", flat(rk.rk_out), rk_exp[5]);
    rst = 1'b0;
    @(negedge clk);
    check("midrst valid", 128'(rk.rk_valid), 128'd0);
    check("midrst busy", 128'(busy), 128'd0);
    check("midrst round", 128'(rk.rk_round), 128'd0);
    check("midrst key", flat(rk.rk_out), 128'd0);
    start  = 1'b1;
    key_in = unflat(KEY);
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    check("start in reset busy", 128'(busy), 128'd0);
    check("start in reset valid", 128'(rk.rk_valid), 128'd0);
    start_op(KEY, 1'b0);
    run_table("restart", fwd);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/key_expander.md
KEY_EXPANDER -- requirements
Module: key_expander

Interface
REQ-001 SHALL have parameter: NR, 10, number of AES-128 rounds; only 10 is supported.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-low reset, sampled on the rising clk edge.
REQ-004 SHALL have port: start  input  1  one-cycle request to begin expansion of key_in.
REQ-005 SHALL have port: key_in  input  [7:0] x [3:0][3:0]  cipher key; key_in[r][c] = key byte 4c+r.
REQ-006 SHALL have port: reverse  input  1  emit order select, sampled with start.
REQ-007 SHALL have port: rk_out  output  [7:0] x [3:0][3:0]  current round key, same byte mapping as key_in; feeds the round stage key input.
REQ-008 SHALL have port: rk_round  output  4  index 0..10 of rk_out.
REQ-009 SHALL have port: rk_valid  output  1  rk_out/rk_round valid.
REQ-010 SHALL have port: rk_ready  input  1  consumer accepts rk_out when rk_valid and rk_ready are both high.
REQ-011 SHALL have port: busy  output  1  high in every state except IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, EXPAND, EMIT.
REQ-013 In IDLE, start=1 SHALL register key_in as round key 0 and initialise Rcon to 0x01.
- Forward mode: go to EMIT.
- Reverse mode: go to EXPAND.
REQ-014 start SHALL be ignored while busy=1.
REQ-015 Each new round key SHALL be computed as follows.
- w0' = w0 ^ SubWord(RotWord(w3)) ^ {Rcon,00,00,00}.
- wi' = wi ^ w(i-1)' for i=1..3, where wc = column c.
- Rcon advances by GF(2^8) doubling, reducing with 0x1B when bit 7 is set, giving 01,02,04,...,80,1B,36.
REQ-016 SubWord SHALL use four instances of the team's existing AES S-box table, one per byte; one round key is produced per clock.
REQ-017 Forward EMIT latency and throughput:
- rk_valid SHALL rise the cycle after start, with rk_round=0.
- On each handshake, the next key SHALL be presented the following cycle.
- With rk_ready held high, keys 0..10 appear on 11 consecutive cycles.
REQ-018 While rk_valid=1 and rk_ready=0, rk_out and rk_round SHALL hold stable.
REQ-019 A handshake on rk_round=10 (forward) or rk_round=0 (reverse) SHALL return the FSM to IDLE, with rk_valid=0 the next cycle.
REQ-020 rk_valid SHALL never be high in IDLE or EXPAND.
REQ-021 rk_ready SHALL be ignored when rk_valid=0.

Reset
REQ-022 rst=0 at a clock edge SHALL, from any state including mid-EMIT or mid-EXPAND, force the following values:
- FSM to IDLE.
- rk_valid=0, busy=0, rk_round=0, rk_out=all zero bytes.
- Rcon=0x01 and the internal key buffer cleared.
REQ-023 start SHALL be ignored in any cycle where rst=0.

Configuration
REQ-024 With macro KEY_EXPANDER_REVERSE_EN defined, the block SHALL support reverse mode.
- It contains an 11-entry round-key buffer.
- EXPAND computes keys 1..10 into the buffer over 10 cycles.
- EMIT then presents keys 10 down to 0, with rk_valid rising 11 cycles after start.
REQ-025 Without KEY_EXPANDER_REVERSE_EN, there SHALL be no buffer or EXPAND state, and reverse SHALL be ignored (always forward).

Verification
REQ-026 Forward FIPS-197 key: key_in=2b7e151628aed2a6abf7158809cf4f3c, start, rk_ready=1.
- Required: rk_round 0..10 on 11 consecutive cycles.
- Round 1 = a0fafe1788542cb123a339392a6c7605.
- Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-027 Backpressure: same key with rk_ready toggled 1,0,0,1,...
- Required: rk_out is held during stalls.
- No key is skipped or repeated; all 11 keys match REQ-026.
REQ-028 Reverse (macro defined): same key with reverse=1.
- Required: first rk_valid 11 cycles after start with rk_round=10 = d014f9a8...0ca6.
- Last key is rk_round=0 = key_in.
REQ-029 Reset mid-operation: rst=0 while rk_round=5 is valid.
- Required: next cycle rk_valid=0, busy=0, rk_out=0.
- A new start then restarts at round 0.
REQ-030 start pulsed while busy with a different key_in.
- Required: ignored; the output sequence is unchanged from the original key.
